// File: rtl/vedic_mul8_seq.sv
// Unsigned 8x8 multiplier sequencer: time-shares one external 4x4 multiplier over four
// cycles, accumulating shifted nibble products behind valid/ready handshakes.
module vedic_mul8_seq #(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_r
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_step;
  logic [7:0]         r_a;
  logic [7:0]         r_b;
  logic [TAG_W-1:0]   r_tag;
  logic [15:0]        r_acc;
  logic [15:0]        w_pp_shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)        w_state_nxt = S_MUL;
      S_MUL:   if (r_step == 2'd3)  w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)       w_state_nxt = S_IDLE;
      default:                      w_state_nxt = S_IDLE;
    endcase
  end

  // Nibble select: step[0] picks the high half of a, step[1] the high half of b.
  assign mul_a = (r_state == S_MUL) ? (r_step[0] ? r_a[7:4] : r_a[3:0]) : 4'd0;
  assign mul_b = (r_state == S_MUL) ? (r_step[1] ? r_b[7:4] : r_b[3:0]) : 4'd0;

  always_comb begin
    w_pp_shifted = {8'd0, mul_r};
    case (r_step)
      2'd1, 2'd2: w_pp_shifted = {4'd0, mul_r, 4'd0};
      2'd3:       w_pp_shifted = {mul_r, 8'd0};
      default:    w_pp_shifted = {8'd0, mul_r};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= 2'd0;
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_tag  <= '0;
      r_acc  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_tag  <= in_tag;
            r_acc  <= 16'd0;
            r_step <= 2'd0;
          end
        end
        S_MUL: begin
          r_acc  <= r_acc + w_pp_shifted;
          r_step <= r_step + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_p     = r_acc;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Directed bench for vedic_mul8_seq with a behavioural 4x4 multiplier on the mul_* port.
module tb_vedic_mul8_seq;

  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = 8'd0;
  logic [7:0]       in_b = 8'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_p;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [3:0]       mul_a;
  logic [3:0]       mul_b;
  logic [7:0]       mul_r;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    logic [15:0]      exp_ma;   // expected mul_a per step, step0 in bits [3:0]
    logic [15:0]      exp_mb;   // expected mul_b per step, step0 in bits [3:0]
    logic [15:0]      exp_p;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  assign mul_r = mul_a * mul_b;

  vedic_mul8_seq #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_r     (mul_r)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transaction from accept to handshake; holds out_ready low for 'stall' cycles.
  task automatic run_vec(input vec_t v, input int stall);
    logic [3:0] ema, emb;
    @(negedge clk);
    check("in_ready before accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = v.a;
    in_b      = v.b;
    in_tag    = v.tag;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~v.a;
    in_b     = ~v.b;
    in_tag   = ~v.tag;
    for (int k = 0; k < 4; k++) begin
      ema = v.exp_ma[k*4 +: 4];
      emb = v.exp_mb[k*4 +: 4];
      check($sformatf("mul pair step%0d", k), {24'd0, mul_a, mul_b}, {24'd0, ema, emb});
      check("busy in MUL", 32'(busy), 32'd1);
      check("out_valid low in MUL", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check("out_valid after E4", 32'(out_valid), 32'd1);
    check("out_p", 32'(out_p), 32'(v.exp_p));
    check("out_tag", 32'(out_tag), 32'(v.tag));
    check("mul idle in DONE", {24'd0, mul_a, mul_b}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_a     = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_p", 32'(out_p), 32'(v.exp_p));
      check("stall out_tag", 32'(out_tag), 32'(v.tag));
      check("stall in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after handshake", 32'(out_valid), 32'd0);
    check("in_ready after handshake", 32'(in_ready), 32'd1);
    check("busy after handshake", 32'(busy), 32'd0);
    check("out_p held in IDLE", 32'(out_p), 32'(v.exp_p));
  endtask

  initial begin
    int          acc_cyc[2];
    int          n_acc;
    logic [15:0] res_p[2];
    logic [TAG_W-1:0] res_tag[2];
    int          n_res;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, tag: 2'd2, exp_ma: 16'hFFFF, exp_mb: 16'hFFFF, exp_p: 16'hFE01};
    vecs[1] = '{a: 8'h3C, b: 8'hA5, tag: 2'd1, exp_ma: 16'h3C3C, exp_mb: 16'hAA55, exp_p: 16'h26AC};
    vecs[2] = '{a: 8'hA7, b: 8'h3E, tag: 2'd3, exp_ma: 16'hA7A7, exp_mb: 16'h33EE, exp_p: 16'h2872};
    vecs[3] = '{a: 8'h07, b: 8'h09, tag: 2'd0, exp_ma: 16'h0707, exp_mb: 16'h0099, exp_p: 16'h003F};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst mul", {24'd0, mul_a, mul_b}, 32'd0);
    check("rst out_p", 32'(out_p), 32'd0);
    check("rst out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 3; i++) run_vec(vecs[i], 0);

    // Consumer stall with extra requests presented
    run_vec(vecs[1], 10);

    // Reset in the middle of 0x12*0x34
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_tag = 2'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst in_ready", 32'(in_ready), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_p", 32'(out_p), 32'd0);
    check("midrst mul", {24'd0, mul_a, mul_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no out_valid after reset", 32'(out_valid), 32'd0);
    end
    run_vec(vecs[3], 0);

    // Back-to-back with out_ready tied high
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1; in_a = 8'h00; in_b = 8'h55; in_tag = 2'd1;
    n_acc = 0;
    n_res = 0;
    for (int c = 0; c < 20; c++) begin
      if (n_acc == 1) begin
        in_a = 8'h01; in_b = 8'h80; in_tag = 2'd2;
      end else if (n_acc == 2) begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (out_valid && n_res < 2) begin
        res_p[n_res]   = out_p;
        res_tag[n_res] = out_tag;
        n_res++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("b2b accept count", 32'(n_acc), 32'd2);
    check("b2b result count", 32'(n_res), 32'd2);
    if (n_acc == 2) check("b2b accept spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    if (n_res == 2) begin
      check("b2b out_p 0", 32'(res_p[0]), 32'h0000);
      check("b2b out_p 1", 32'(res_p[1]), 32'h0080);
      check("b2b out_tag 1", 32'(res_tag[1]), 32'd2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
